// File: rtl/led_scan_if.sv
// Host-side bundle for the scan controller: display value and controls in,
// decoder nibble and anode selects out.
interface led_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    blank_lz;
    logic [3:0]              nibble_out;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_start;

    modport master (
        output value_in, load, digit_en, blank_lz,
        input  nibble_out, an_n, frame_start
    );

    modport slave (
        input  value_in, load, digit_en, blank_lz,
        output nibble_out, an_n, frame_start
    );
endinterface

// File: rtl/led_scan.sv
// Multiplexed seven-segment scan controller with dead-time between digits,
// frame-synchronous value update and leading-zero blanking.
module led_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    led_scan_if.slave   bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    // cnt/idx name the slot position that the next edge enters, so every
    // registered output is computed for the cycle it will be visible in.
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    first;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_valid;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] shadow_nx;
    logic                    wrap;
    logic                    blanked;
    logic                    lit;
    logic [3:0]              nib_nx;

    always_comb begin
        // cycle 0 after reset also enters idx 0 / cnt 0, but is not a wrap
        wrap      = (cnt == '0) && (idx == '0) && !first;
        shadow_nx = shadow;
        if (wrap) begin
            if (bus.load)
                shadow_nx = bus.value_in;
            else if (pending_valid)
                shadow_nx = pending;
        end
        nib_nx  = 4'(shadow_nx >> {idx, 2'b00});
        blanked = bus.blank_lz && (idx != '0) && ((shadow_nx >> {idx, 2'b00}) == '0);
        lit     = (cnt >= CW'(DEAD_CYC)) && bus.digit_en[idx] && !blanked;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            idx             <= '0;
            first           <= 1'b1;
            pending         <= '0;
            pending_valid   <= 1'b0;
            shadow          <= '0;
            bus.nibble_out  <= 4'd0;
            bus.an_n        <= '1;
            bus.frame_start <= 1'b0;
        end else begin
            first <= 1'b0;
            if (cnt == CW'(SCAN_DIV-1)) begin
                cnt <= '0;
                idx <= (idx == IW'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // a load on the wrap edge bypasses pending and drops any older value
            shadow <= shadow_nx;
            if (wrap) begin
                pending_valid <= 1'b0;
            end else if (bus.load) begin
                pending       <= bus.value_in;
                pending_valid <= 1'b1;
            end

            if (cnt == '0)
                bus.nibble_out <= nib_nx;
            bus.an_n        <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            bus.frame_start <= wrap;
        end
    end
endmodule

// File: tb/tb_led_scan.sv
// Directed bench for led_scan: a cycle model pushes expected outputs to a
// queue per edge, popped and compared just after that edge.
module tb_led_scan;
    localparam int N = 4;
    localparam int S = 8;
    localparam int D = 2;

    typedef struct packed {
        logic [N-1:0] an;
        logic [3:0]   nib;
        logic         fs;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   t;

    logic [4*N-1:0] m_shadow;
    logic [4*N-1:0] m_pend;
    bit             m_pv;
    exp_t           q[$];

    led_scan_if #(.NUM_DIGITS(N)) bus ();

    led_scan #(.NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYC(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_shadow = '0;
        m_pend   = '0;
        m_pv     = 1'b0;
        t        = 0;
        q.delete();
    endtask

    task automatic step();
        exp_t e;
        int   slot;
        int   pos;
        bit   wrap;
        wrap = (t > 0) && (t % (N*S) == 0);
        if (wrap) begin
            if (bus.load)  m_shadow = bus.value_in;
            else if (m_pv) m_shadow = m_pend;
            m_pv = 1'b0;
        end else if (bus.load) begin
            m_pend = bus.value_in;
            m_pv   = 1'b1;
        end
        slot  = (t / S) % N;
        pos   = t % S;
        e.nib = m_shadow[slot*4 +: 4];
        e.an  = '1;
        if (pos >= D && bus.digit_en[slot] &&
            !(bus.blank_lz && slot > 0 && (m_shadow >> (4*slot)) == 0))
            e.an[slot] = 1'b0;
        e.fs = wrap;
        q.push_back(e);

        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("an_n",        8'(bus.an_n),        8'(e.an));
        chk("nibble_out",  8'(bus.nibble_out),  8'(e.nib));
        chk("frame_start", 8'(bus.frame_start), 8'(e.fs));
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    task automatic load_at(input logic [4*N-1:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.value_in = '0;
        bus.load     = 1'b0;
        bus.digit_en = '1;
        bus.blank_lz = 1'b0;
        model_reset();

        #12;
        chk("rst_an_n",  8'(bus.an_n),        8'h0F);
        chk("rst_nib",   8'(bus.nibble_out),  8'h00);
        chk("rst_fs",    8'(bus.frame_start), 8'h00);
        rst_n = 1'b1;

        // idle frame, then a buffered load applied at the first wrap
        run_to(5);
        load_at(16'h1234);
        // two loads in one frame: last wins
        run_to(40);
        load_at(16'hAAAA);
        run_to(50);
        load_at(16'h5A5A);
        // leading-zero blanking
        run_to(100);
        bus.blank_lz = 1'b1;
        load_at(16'h0007);
        run_to(160);
        load_at(16'h0000);
        // per-digit enable, then a load exactly on the wrap edge
        run_to(224);
        bus.blank_lz = 1'b0;
        bus.digit_en = 4'b1011;
        load_at(16'hFFFF);
        run_to(270);
        load_at(16'h1111);
        run_to(288);
        load_at(16'hC0DE);
        // pending value lost by an asynchronous reset in mid-DRIVE of digit 2
        run_to(330);
        bus.digit_en = '1;
        load_at(16'h9876);
        run_to(341);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an_n", 8'(bus.an_n),        8'h0F);
        chk("async_rst_nib",  8'(bus.nibble_out),  8'h00);
        chk("async_rst_fs",   8'(bus.frame_start), 8'h00);
        model_reset();
        @(posedge clk);
        #2;
        chk("hold_rst_an_n",  8'(bus.an_n),        8'h0F);
        rst_n = 1'b1;
        run_to(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
